// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: issues one instruction-memory request per instruction,
// waits for completion and hands the word to decode with a valid/stall handshake.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic [15:0] imem_rdata,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt_in,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  output logic        halted,
  output logic        err
);

  localparam int unsigned AW = 16;
  localparam logic [AW-1:0] PC_MASK = 16'hFFFE;
  localparam logic [AW-1:0] PC_STEP = 16'd2;

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [AW-1:0] target;
  logic          done_unexpected;

  // Instruction addresses are halfword aligned; bit 0 is dropped on every load.
  assign target          = redirect_pc & PC_MASK;
  assign imem_req        = (state == S_REQ);
  assign imem_addr       = pc;
  assign pc_plus2        = AW'(pc_out + PC_STEP);
  assign done_unexpected = imem_done &&
                           (state == S_REQ || state == S_HOLD || state == S_HALT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC & PC_MASK;
      instr_out   <= NOP_INSTR;
      pc_out      <= RESET_PC;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= done_unexpected;
      case (state)
        S_REQ: begin
          if (redirect_valid) begin
            pc          <= target;
            instr_valid <= 1'b0;
            instr_out   <= NOP_INSTR;
            // An access accepted this cycle must still be drained.
            if (!imem_stall) state <= S_DRAIN;
          end else if (!imem_stall) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc          <= target;
            instr_valid <= 1'b0;
            instr_out   <= NOP_INSTR;
            state       <= imem_done ? S_REQ : S_DRAIN;
          end else if (imem_done) begin
            instr_out   <= imem_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            pc          <= AW'(pc + PC_STEP);
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc          <= target;
            instr_valid <= 1'b0;
            instr_out   <= NOP_INSTR;
            state       <= S_REQ;
          end else if (!stall_in) begin
            instr_valid <= 1'b0;
            instr_out   <= NOP_INSTR;
            if (halt_in) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_DRAIN: begin
          // Redirect wins over a same-cycle completion, so draining continues.
          if (redirect_valid) begin
            pc          <= target;
            instr_valid <= 1'b0;
            instr_out   <= NOP_INSTR;
          end else if (imem_done) begin
            state <= S_REQ;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: randomized memory/decode stimulus checked every cycle
// against a transaction-level model, plus directed scenarios with literal checks.
module tb_fetch_ctrl;

  localparam logic [15:0] NOP = 16'h0800;
  localparam logic [15:0] KEY = 16'h5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_stall;
  logic        imem_done;
  logic [15:0] imem_rdata;
  logic        stall_in;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_in;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic        halted;
  logic        err;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_stall(imem_stall),
    .imem_done(imem_done), .imem_rdata(imem_rdata),
    .stall_in(stall_in), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_in(halt_in), .instr_out(instr_out), .pc_out(pc_out), .pc_plus2(pc_plus2),
    .instr_valid(instr_valid), .halted(halted), .err(err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: the fetcher is either halted, holding an instruction, has an access
  // in flight (possibly already doomed by a redirect), or is asking for one.
  logic [15:0] m_pc, m_instr, m_pco;
  logic        m_valid, m_busy, m_disc, m_halted, m_err;

  always @(posedge clk) begin : model
    logic        asking;
    logic [15:0] n_pc, n_instr, n_pco;
    logic        n_valid, n_busy, n_disc, n_halted, n_err;
    asking  = !m_halted && !m_valid && !m_busy;
    n_pc = m_pc; n_instr = m_instr; n_pco = m_pco; n_valid = m_valid;
    n_busy = m_busy; n_disc = m_disc; n_halted = m_halted; n_err = 1'b0;
    if (!rst) begin
      n_pc = 16'h0000; n_instr = NOP; n_pco = 16'h0000; n_valid = 1'b0;
      n_busy = 1'b0; n_disc = 1'b0; n_halted = 1'b0;
    end else begin
      n_err = imem_done && !m_busy;
      if (m_halted) begin
        n_halted = 1'b1;
      end else if (redirect_valid) begin
        n_pc = redirect_pc & 16'hFFFE; n_valid = 1'b0; n_instr = NOP;
        if (asking) begin
          n_busy = !imem_stall; n_disc = !imem_stall;
        end else if (m_busy && !m_disc) begin
          n_busy = !imem_done; n_disc = !imem_done;
        end
      end else if (asking) begin
        if (!imem_stall) begin n_busy = 1'b1; n_disc = 1'b0; end
      end else if (m_busy) begin
        if (imem_done) begin
          n_busy = 1'b0; n_disc = 1'b0;
          if (!m_disc) begin
            n_instr = imem_rdata; n_pco = m_pc; n_valid = 1'b1; n_pc = m_pc + 16'd2;
          end
        end
      end else if (m_valid && !stall_in) begin
        n_valid = 1'b0; n_instr = NOP; n_halted = halt_in;
      end
    end
    m_pc <= n_pc; m_instr <= n_instr; m_pco <= n_pco; m_valid <= n_valid;
    m_busy <= n_busy; m_disc <= n_disc; m_halted <= n_halted; m_err <= n_err;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("imem_req",    16'(imem_req),    16'(!m_halted && !m_valid && !m_busy));
    chk("imem_addr",   imem_addr,        m_pc);
    chk("instr_out",   instr_out,        m_instr);
    chk("pc_out",      pc_out,           m_pco);
    chk("pc_plus2",    pc_plus2,         16'(m_pco + 16'd2));
    chk("instr_valid", 16'(instr_valid), 16'(m_valid));
    chk("halted",      16'(halted),      16'(m_halted));
    chk("err",         16'(err),         16'(m_err));
  endtask

  // Memory responder: in-order responses after a per-request latency.
  typedef struct {int due; logic [15:0] addr;} rsp_t;
  rsp_t        q[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1, lat_max = 1, stall_pct = 0, spur_pct = 0;
  bit          force_stall = 1'b0;
  bit          redir_on_done = 1'b0;
  bit          redir_fired = 1'b0;
  logic [15:0] redir_tgt = 16'h0000;

  task automatic drive_mem();
    rsp_t r;
    int   lat, due;
    imem_done  = 1'b0;
    imem_rdata = 16'($urandom);
    if (q.size() > 0 && q[0].due <= cyc) begin
      r = q.pop_front();
      imem_done  = 1'b1;
      imem_rdata = r.addr ^ KEY;
    end else if (int'($urandom_range(99, 0)) < spur_pct) begin
      imem_done = 1'b1;
    end
    if (redir_on_done && imem_done) begin
      redirect_valid = 1'b1; redirect_pc = redir_tgt;
      redir_on_done = 1'b0; redir_fired = 1'b1;
    end
    imem_stall = force_stall || (int'($urandom_range(99, 0)) < stall_pct);
    if (rst && imem_req === 1'b1 && !imem_stall) begin
      lat = int'($urandom_range(lat_max, lat_min));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.due = due; r.addr = imem_addr;
      q.push_back(r);
    end
  endtask

  // Apply the cycle's inputs, pass the clock edge, then check against the model.
  task automatic tick();
    drive_mem();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic wait_valid(input string name, input logic [15:0] pc_exp, input logic [15:0] ins_exp);
    int n = 0;
    do begin tick(); n++; end while (instr_valid !== 1'b1 && n < 40);
    chk({name, "_valid"}, 16'(instr_valid), 16'd1);
    chk({name, "_pc"}, pc_out, pc_exp);
    chk({name, "_instr"}, instr_out, ins_exp);
  endtask

  task automatic wait_period(input string name, input int n_exp);
    int n = 0;
    do begin tick(); n++; end while (instr_valid !== 1'b1 && n < 40);
    chk(name, 16'(n), 16'(n_exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    halt_in = 1'b0; imem_stall = 1'b0; imem_done = 1'b0; imem_rdata = 16'h0000;

    // Reset state
    tick(); tick();
    chk("rst_req", 16'(imem_req), 16'd1);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", 16'(instr_valid), 16'd0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_plus2", pc_plus2, 16'h0002);
    chk("rst_halted", 16'(halted), 16'd0);
    rst = 1'b1;

    // Sequential fetch, one instruction every 3 cycles
    wait_period("first_latency", 2);
    chk("seq0_pc", pc_out, 16'h0000); chk("seq0_instr", instr_out, 16'h5A5A);
    wait_period("period1", 3);
    chk("seq1_pc", pc_out, 16'h0002); chk("seq1_instr", instr_out, 16'h5A58);
    wait_period("period2", 3);
    chk("seq2_pc", pc_out, 16'h0004); chk("seq2_instr", instr_out, 16'h5A5E);

    // Memory stall holds the request
    force_stall = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mstall_req", 16'(imem_req), 16'd1);
      chk("mstall_addr", imem_addr, 16'h0006);
    end
    force_stall = 1'b0;
    wait_valid("after_mstall", 16'h0006, 16'h5A5C);

    // Decode stall freezes the held instruction
    stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("dstall_valid", 16'(instr_valid), 16'd1);
      chk("dstall_pc", pc_out, 16'h0006);
      chk("dstall_req", 16'(imem_req), 16'd0);
    end
    stall_in = 1'b0; lat_min = 3; lat_max = 3;
    tick();
    chk("release_valid", 16'(instr_valid), 16'd0);
    chk("release_instr", instr_out, NOP);
    chk("release_addr", imem_addr, 16'h0008);

    // Redirect while an access is in flight
    tick();
    chk("inflight_req", 16'(imem_req), 16'd0);
    redirect_valid = 1'b1; redirect_pc = 16'h0123;
    tick();
    redirect_valid = 1'b0;
    chk("drain_req", 16'(imem_req), 16'd0);
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
    chk("drain_done_req", 16'(imem_req), 16'd1);
    chk("redir_addr", imem_addr, 16'h0122);
    wait_valid("redir", 16'h0122, 16'h5B78);

    // Redirect in the same cycle as completion
    lat_min = 2; lat_max = 2;
    redir_tgt = 16'h0200; redir_fired = 1'b0; redir_on_done = 1'b1;
    for (int i = 0; i < 20 && !redir_fired; i++) tick();
    redirect_valid = 1'b0; redir_on_done = 1'b0;
    chk("samecyc_fired", 16'(redir_fired), 16'd1);
    chk("samecyc_req", 16'(imem_req), 16'd1);
    chk("samecyc_addr", imem_addr, 16'h0200);
    chk("samecyc_instr", instr_out, NOP);

    // Redirect in HOLD beats halt
    wait_valid("hold", 16'h0200, 16'h585A);
    redirect_valid = 1'b1; redirect_pc = 16'h0300; halt_in = 1'b1;
    tick();
    redirect_valid = 1'b0; halt_in = 1'b0;
    chk("holdredir_valid", 16'(instr_valid), 16'd0);
    chk("holdredir_halted", 16'(halted), 16'd0);
    chk("holdredir_addr", imem_addr, 16'h0300);

    // PC wrap-around, odd target forced even
    redirect_valid = 1'b1; redirect_pc = 16'hFFFD;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_target", imem_addr, 16'hFFFC);
    wait_valid("wrap0", 16'hFFFC, 16'hA5A6);
    wait_valid("wrap1", 16'hFFFE, 16'hA5A4);
    chk("wrap1_plus2", pc_plus2, 16'h0000);
    wait_valid("wrap2", 16'h0000, 16'h5A5A);
    chk("wrap2_plus2", pc_plus2, 16'h0002);

    // Halt: everything but reset ignored, stray completion flagged
    halt_in = 1'b1;
    tick();
    halt_in = 1'b0;
    chk("halt_halted", 16'(halted), 16'd1);
    chk("halt_req", 16'(imem_req), 16'd0);
    spur_pct = 100; redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick();
    spur_pct = 0; redirect_valid = 1'b0;
    chk("halt_err", 16'(err), 16'd1);
    chk("halt_addr", imem_addr, 16'h0002);
    tick();
    chk("halt_err_pulse", 16'(err), 16'd0);
    chk("halt_stays", 16'(halted), 16'd1);

    // Reset mid-access: late completion arrives in REQ
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("restart_halted", 16'(halted), 16'd0);
    chk("restart_addr", imem_addr, 16'h0000);
    lat_min = 3; lat_max = 3;
    wait_valid("restart", 16'h0000, 16'h5A5A);
    tick(); tick();
    chk("midacc_wait", 16'(imem_req), 16'd0);
    rst = 1'b0; force_stall = 1'b1;
    tick();
    rst = 1'b1;
    chk("midacc_req", 16'(imem_req), 16'd1);
    for (int i = 0; i < 20 && imem_done !== 1'b1; i++) tick();
    chk("late_err", 16'(err), 16'd1);
    chk("late_valid", 16'(instr_valid), 16'd0);
    chk("late_addr", imem_addr, 16'h0000);
    force_stall = 1'b0;
    wait_valid("after_late", 16'h0000, 16'h5A5A);

    // Randomized traffic
    lat_min = 1; lat_max = 4; stall_pct = 25; spur_pct = 2;
    for (int i = 0; i < 3000; i++) begin
      stall_in       = (int'($urandom_range(99, 0)) < 30);
      redirect_valid = (int'($urandom_range(99, 0)) < 8);
      redirect_pc    = 16'($urandom);
      halt_in        = (int'($urandom_range(99, 0)) < 8);
      rst            = !(int'($urandom_range(99, 0)) < 3);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
